id_decode_queue: RTL and testbench

//  Decoupling instruction queue plus registered main decoder for the MIPS ID stage.

---
 rtl/id_decode_queue.sv | 164 ++++++++++++++++
 tb/tb_id_decode_queue.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_decode_queue.sv
// ID-stage instruction queue: DEPTH-entry FIFO behind a registered main-decoder output stage.
// Optional feature macro: DEC_COP0_EN enables eret/mtc0/mfc0 decode of COP0 (op 010000).
module id_decode_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [31:0]                      in_instr,
  input  logic [PC_W-1:0]                  in_pc,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [31:0]                      out_instr,
  output logic [PC_W-1:0]                  out_pc,
  output logic [15:0]                      out_ctrl,
  output logic [$clog2(DEPTH+2)-1:0]       occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 2);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [OCC_W-1:0]   count;
  logic [OCC_W-1:0]   count_nxt;

  logic   fifo_empty;
  logic   fifo_full;
  logic   push;
  logic   pop;
  logic   load;
  logic   from_fifo;
  logic   bypass;
  logic   fifo_wr;
  logic   valid_nxt;
  entry_t src;

  // Control word order: regwrite,regdst,alusrc,branch,memtoreg,jump,jal,jr,
  // bal,hilo_en,brk,syscall,reserve,eret,mtc0_we,mfc0
  function automatic logic [15:0] decode(input logic [31:0] instr);
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [5:0]  fn;
    logic [15:0] ctrl;
    op   = instr[31:26];
    rs   = instr[25:21];
    rt   = instr[20:16];
    fn   = instr[5:0];
    ctrl = 16'h0008;
    case (op)
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F: ctrl = 16'hA000;
      6'h20, 6'h21, 6'h23,
      6'h24, 6'h25:               ctrl = 16'hA800;
      6'h28, 6'h29, 6'h2B:        ctrl = 16'h2000;
      6'h02:                      ctrl = 16'h0400;
      6'h03:                      ctrl = 16'h8200;
      6'h04, 6'h05, 6'h06, 6'h07: ctrl = 16'h1000;
      6'h01: begin
        case (rt)
          5'h00, 5'h01: ctrl = 16'h1000;
          5'h10, 5'h11: ctrl = 16'h9080;
          default:      ctrl = 16'h0008;
        endcase
      end
      6'h00: begin
        case (fn)
          6'h10, 6'h12:               ctrl = 16'hC000;
          6'h11, 6'h13, 6'h18,
          6'h19, 6'h1A, 6'h1B:        ctrl = 16'h0040;
          6'h08:                      ctrl = 16'h0100;
          6'h09:                      ctrl = 16'hC100;
          6'h0C:                      ctrl = 16'h0010;
          6'h0D:                      ctrl = 16'h0020;
          6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B, 6'h00, 6'h02,
          6'h03, 6'h04, 6'h06, 6'h07: ctrl = 16'hC000;
          default:                    ctrl = 16'h0008;
        endcase
      end
`ifdef DEC_COP0_EN
      6'h10: begin
        if (instr == 32'h4200_0018)                     ctrl = 16'h0004;
        else if (rs == 5'b00100 && instr[10:3] == 8'h0) ctrl = 16'h0002;
        else if (rs == 5'b00000 && instr[10:3] == 8'h0) ctrl = 16'h8001;
        else                                            ctrl = 16'h0008;
      end
`else
      6'h10: ctrl = (rs == rs) ? 16'h0008 : 16'h0008;
`endif
      default: ctrl = 16'h0008;
    endcase
    return ctrl;
  endfunction

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == OCC_W'(DEPTH));
  assign in_ready   = resetn & ~fifo_full;
  assign push       = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign load       = ~out_valid | pop;
  assign from_fifo  = load & ~fifo_empty;
  // A push into an empty queue goes straight to the output register
  assign bypass     = load & fifo_empty & push;
  assign fifo_wr    = push & ~bypass;
  assign valid_nxt  = from_fifo | bypass | (out_valid & ~out_ready);
  assign count_nxt  = count + OCC_W'(fifo_wr) - OCC_W'(from_fifo);

  always_comb begin
    src = '0;
    if (from_fifo) src = mem[rd_ptr];
    else           src = '{pc: in_pc, instr: in_instr};
  end

  // Storage array needs no reset; pointers and count define validity
  always_ff @(posedge clk) begin
    if (fifo_wr && !flush) mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      out_ctrl  <= '0;
      occupancy <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      occupancy <= '0;
    end else begin
      if (fifo_wr)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (from_fifo) rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_nxt;
      out_valid <= valid_nxt;
      occupancy <= count_nxt + OCC_W'(valid_nxt);
      if (from_fifo || bypass) begin
        out_instr <= src.instr;
        out_pc    <= src.pc;
        out_ctrl  <= decode(src.instr);
      end else if (load) begin
        out_ctrl  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_id_decode_queue.sv
// Randomised self-checking bench for id_decode_queue against a queue-level reference model.
module tb_id_decode_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [15:0] out_ctrl;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] acc[$];

  id_decode_queue #(.DEPTH(DEPTH), .PC_W(32)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_ctrl(out_ctrl), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_ctrl(input logic [31:0] i);
    logic [5:0] op;
    logic [4:0] rt;
    logic [5:0] fn;
    op = i[31:26];
    rt = i[20:16];
    fn = i[5:0];
    if (op inside {[6'h08:6'h0F]})              return 16'hA000;
    if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) return 16'hA800;
    if (op inside {6'h28, 6'h29, 6'h2B})         return 16'h2000;
    if (op == 6'h02)                             return 16'h0400;
    if (op == 6'h03)                             return 16'h8200;
    if (op inside {[6'h04:6'h07]})               return 16'h1000;
    if (op == 6'h01) begin
      if (rt inside {5'h00, 5'h01}) return 16'h1000;
      if (rt inside {5'h10, 5'h11}) return 16'h9080;
      return 16'h0008;
    end
    if (op == 6'h00) begin
      if (fn inside {6'h10, 6'h12, [6'h20:6'h27], 6'h2A, 6'h2B,
                     6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07}) return 16'hC000;
      if (fn inside {6'h11, 6'h13, [6'h18:6'h1B]}) return 16'h0040;
      if (fn == 6'h08) return 16'h0100;
      if (fn == 6'h09) return 16'hC100;
      if (fn == 6'h0C) return 16'h0010;
      if (fn == 6'h0D) return 16'h0020;
      return 16'h0008;
    end
`ifdef DEC_COP0_EN
    if (op == 6'h10) begin
      if (i == 32'h4200_0018) return 16'h0004;
      if (i[25:21] == 5'd4 && i[10:3] == 8'd0) return 16'h0002;
      if (i[25:21] == 5'd0 && i[10:3] == 8'd0) return 16'h8001;
      return 16'h0008;
    end
`endif
    return 16'h0008;
  endfunction

  // One clock of stimulus; the model is a single ordered list of live entries
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    logic rdy_m, push_m, pop_m;
    ent_t e;
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    rdy_m  = (mq.size() <= DEPTH);
    pop_m  = ordy && (mq.size() > 0);
    push_m = iv && rdy_m;
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (pop_m) e = mq.pop_front();
      if (push_m) begin
        e.instr = ins;
        e.pc    = pc;
        mq.push_back(e);
        acc.push_back(ins);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL reset_init: in_ready=%b out_valid=%b occ=%0d, want 0/0/0", in_ready, out_valid, occupancy);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b want 1", in_ready);
    end
    for (int k = 0; k < 3; k++) cycle(1'b1, 32'h3400_0000 + k, 32'h100 + 4*k, 1'b0, 1'b0);
    checks++;
    if (occupancy !== 3'd3) begin
      errors++;
      $display("FAIL reset_fill: occ=%0d want 3", occupancy);
    end
    resetn   = 1'b0;
    in_valid = 1'b1;
    #1;
    checks++;
    if (occupancy !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: occ=%0d out_valid=%b in_ready=%b want 0/0/0", occupancy, out_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL reset_hold: in_ready=%b occ=%0d want 0/0", in_ready, occupancy);
    end
    mq.delete();
    in_valid = 1'b0;
    resetn   = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_after: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_bypass();
    cycle(1'b1, 32'h3408_0005, 32'hBFC0_0000, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_ctrl !== 16'hA000 || out_pc !== 32'hBFC0_0000 ||
        out_instr !== 32'h3408_0005 || occupancy !== 3'd1) begin
      errors++;
      $display("FAIL bypass: v=%b ctrl=%h pc=%h instr=%h occ=%0d want 1/a000/bfc00000/34080005/1",
               out_valid, out_ctrl, out_pc, out_instr, occupancy);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL bypass_drain: v=%b occ=%0d want 0/0", out_valid, occupancy);
    end
  endtask

  task automatic test_full();
    logic [31:0] got[$];
    acc.delete();
    for (int k = 0; k < DEPTH + 1; k++)
      cycle(1'b1, 32'h2400_1000 + k, 32'h200 + 4*k, 1'b0, 1'b0);
    checks++;
    if (occupancy !== 3'd5 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full: occ=%0d in_ready=%b want 5/0", occupancy, in_ready);
    end
    cycle(1'b1, 32'hDEAD_0001, 32'h0, 1'b0, 1'b0);
    got.push_back(out_instr);
    cycle(1'b1, 32'hDEAD_0002, 32'h0, 1'b1, 1'b0);
    checks++;
    if (occupancy !== 3'd4 || out_instr !== 32'h2400_1001) begin
      errors++;
      $display("FAIL full_pop: occ=%0d instr=%h want 4/24001001", occupancy, out_instr);
    end
    for (int k = 0; k < 20 && mq.size() > 0; k++) begin
      if (out_valid) got.push_back(out_instr);
      cycle(k < 3, 32'h2400_2000 + k, 32'h300 + 4*k, 1'b1, 1'b0);
    end
    checks++;
    if (got.size() != acc.size() || mq.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_count: popped=%0d accepted=%0d v=%b", got.size(), acc.size(), out_valid);
    end else begin
      foreach (got[k]) begin
        checks++;
        if (got[k] !== acc[k]) begin
          errors++;
          $display("FAIL drain_order[%0d]: got %h want %h", k, got[k], acc[k]);
        end
      end
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) cycle(1'b1, 32'h2000_0000 + k, 32'h400 + 4*k, 1'b0, 1'b0);
    checks++;
    if (occupancy !== 3'd3) begin
      errors++;
      $display("FAIL flush_fill: occ=%0d want 3", occupancy);
    end
    cycle(1'b1, 32'h2000_00AA, 32'h500, 1'b1, 1'b1);
    checks++;
    if (occupancy !== 3'd0 || out_valid !== 1'b0 || out_ctrl !== 16'h0) begin
      errors++;
      $display("FAIL flush: occ=%0d v=%b ctrl=%h want 0/0/0000", occupancy, out_valid, out_ctrl);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (occupancy !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_lost: occ=%0d v=%b want 0/0", occupancy, out_valid);
    end
  endtask

  task automatic test_decode();
    logic [31:0] ins [14];
    logic [15:0] exp [14];
    ins = '{32'h8C00_0000, 32'h0000_0009, 32'h0411_0000, 32'h0000_000C, 32'h0000_003F,
            32'hFC00_0000, 32'h0800_0000, 32'hA000_0000, 32'h0000_0018, 32'h0000_000D,
            32'h0405_0000, 32'h1000_0000, 32'h4200_0018, 32'h4082_6000};
`ifdef DEC_COP0_EN
    exp = '{16'hA800, 16'hC100, 16'h9080, 16'h0010, 16'h0008, 16'h0008, 16'h0400,
            16'h2000, 16'h0040, 16'h0020, 16'h0008, 16'h1000, 16'h0004, 16'h0002};
`else
    exp = '{16'hA800, 16'hC100, 16'h9080, 16'h0010, 16'h0008, 16'h0008, 16'h0400,
            16'h2000, 16'h0040, 16'h0020, 16'h0008, 16'h1000, 16'h0008, 16'h0008};
`endif
    foreach (ins[k]) begin
      cycle(1'b1, ins[k], 32'h600 + 4*k, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_ctrl !== exp[k]) begin
        errors++;
        $display("FAIL decode[%h]: v=%b ctrl=%h want 1/%h", ins[k], out_valid, out_ctrl, exp[k]);
      end
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [5:0]  ops [12];
    logic [31:0] ins;
    ops = '{6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h0D, 6'h23, 6'h2B, 6'h10, 6'h3F, 6'h09};
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      if ($urandom_range(3) != 0) ins[31:26] = ops[$urandom_range(11)];
      cycle($urandom_range(2) != 0, ins, $urandom, $urandom_range(9) < 6, $urandom_range(49) == 0);
      checks++;
      if (out_valid !== (mq.size() > 0) || occupancy !== 3'(mq.size()) ||
          in_ready !== (mq.size() <= DEPTH)) begin
        errors++;
        $display("FAIL rand_state@%0d: v=%b occ=%0d rdy=%b want size %0d", n, out_valid, occupancy, in_ready, mq.size());
      end else if (mq.size() > 0) begin
        checks++;
        if (out_instr !== mq[0].instr || out_pc !== mq[0].pc || out_ctrl !== ref_ctrl(mq[0].instr)) begin
          errors++;
          $display("FAIL rand_head@%0d: instr=%h pc=%h ctrl=%h want %h/%h/%h", n, out_instr, out_pc,
                   out_ctrl, mq[0].instr, mq[0].pc, ref_ctrl(mq[0].instr));
        end
      end
    end
  endtask

  initial begin
    resetn    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    #2;
    test_reset();
    test_bypass();
    test_full();
    test_flush();
    test_decode();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
